piezo_alert_sched: RTL
======================

Name: piezo_alert_sched

Overview:
- Scheduler between the raw Segway alert conditions (steer enable, over-speed, low battery) and the piezo tune player.
- Qualifies each condition against glitches and picks the highest-priority active alert.
- Starts and aborts tunes on the player through a level req/ack handshake, and paces tune repeats.
- The player only plays the tune it is told to; all priority, preemption and repeat timing is owned here.

Parameters:
- fast_sim, 1: selects shortened timing for simulation.
- QUAL_CYC, fast_sim ? 32 : 500_000: cycles a condition must be continuously high before it is qualified (10 ms at 50 MHz).
- REPEAT_CYC, fast_sim ? 15_000 : 150_000_000: idle gap after a STEER or BATT tune before it replays (3 s at 50 MHz).
- QW, $clog2(QUAL_CYC+1): width of the qualification counters.
- RW, $clog2(REPEAT_CYC+1): width of the gap counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active low
- en_steer  in  1  rider-present / steering-enabled condition
- too_fast  in  1  over-speed condition
- batt_low  in  1  battery-low condition
- tone_busy  in  1  player is playing a tune (ack)
- tone_start  out  1  start request; level, held until acked
- tone_abort  out  1  abort request; level, held until tone_busy falls
- tone_sel  out  2  tune ID: 0 none, 1 STEER, 2 BATT, 3 FAST; stable while tone_start or tone_busy
- alert_act  out  2  currently owned alert ID (same encoding), for the status LED

Behaviour:
- Reset values: tone_start=0, tone_abort=0, tone_sel=0, alert_act=0, state IDLE, all counters 0.
- Qualification, per source:
  - Counter increments while the input is high, saturating at QUAL_CYC.
  - Any low cycle clears the counter to 0.
  - qual_x = (cnt_x == QUAL_CYC), registered, so the first qualified cycle is QUAL_CYC+1 clocks after the input rises.
  - Deassertion is immediate: qual_x drops the cycle after the input falls.
- Priority: want = FAST if qual_fast, else BATT if qual_batt, else STEER if qual_steer, else 0.
- FSM states: IDLE, START, PLAY, ABORT, GAP.
  - IDLE: if want != 0, latch tone_sel=want and alert_act=want, go to START.
  - START: tone_start=1. When tone_busy=1, drop tone_start next cycle and go to PLAY.
    - If want falls to 0 before the ack: drop tone_start, tone_sel=0, go to IDLE.
    - If want rises above tone_sel before the ack: relatch tone_sel, stay in START.
  - PLAY: tone_busy falling ends the tune.
    - FAST ended with qual_fast still set: go straight to START (back-to-back, no gap).
    - Otherwise go to GAP with the gap counter cleared.
    - If want > tone_sel while busy: go to ABORT. want falling to 0 does NOT abort; the tune plays out.
  - ABORT: tone_abort=1 until tone_busy=0, then tone_abort=0, latch tone_sel=want, go to START. If want=0 at that point, go to IDLE.
  - GAP: counter counts up; tone_sel=0; alert_act holds.
    - Counter reaches REPEAT_CYC with want != 0: latch want, go to START.
    - Counter reaches REPEAT_CYC with want = 0: go to IDLE.
    - want > alert_act: leave the gap immediately, latch, go to START.
    - want = 0 for any cycle: alert_act=0, go to IDLE.
- Simultaneous events:
  - Ack and a higher-priority want in the same START cycle: the ack wins; go to PLAY, then abort from PLAY next cycle.
  - tone_busy falling and a higher want in the same PLAY cycle: no abort; go directly to START with the new ID.
- Protocol invariants:
  - tone_start and tone_abort are never both high.
  - tone_sel never changes while tone_busy=1.
- Mid-operation rst_n: all outputs go to reset values asynchronously. The player must treat tone_start=0 with tone_sel=0 as a stop.

Decomposition:
- Shared package piezo_pkg:
  - typedef alert_t (2-bit enum NONE, STEER, BATT, FAST); the player reuses it.
  - typedef sched_state_t.
  - Localparams for the 50 MHz-derived QUAL_CYC and REPEAT_CYC.
- One sub-module alert_qual: a single-bit saturating qualification counter, parameterised by QUAL_CYC. Instantiated three times.

Test Plan:
- en_steer high for 20 cycles then low (fast_sim) -> never qualified; tone_start stays 0.
- en_steer held high, player model acks in 2 cycles and stays busy 100 cycles -> tone_start rises at cycle 33; tone_sel=1; after busy falls, gap of 15_000 cycles, then second tone_start with tone_sel=1.
- Steer playing, too_fast rises and is held -> tone_abort 33 cycles after too_fast rises, held until busy falls; then tone_start with tone_sel=3; FAST repeats with no gap.
- batt_low and en_steer raised on the same cycle -> tone_sel=2 only; no STEER start ever issued while batt_low is held.
- en_steer dropped during GAP -> alert_act=0 the next cycle; state IDLE; no further tone_start.
- rst_n pulsed low during PLAY -> tone_start, tone_abort, tone_sel and alert_act all 0 asynchronously; after release, nothing starts for QUAL_CYC+1 cycles.

Source files
------------

// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo alert scheduler and the tune player.
//   alert_t        tune / alert ID, ordered so a larger value is a higher priority
//   sched_state_t  scheduler FSM states
//   *_CYC_*        timing constants: real 50 MHz values and shortened sim values
//   pick_alert()   priority encoder from qualified conditions to the wanted alert
package piezo_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        STEER = 2'd1,
        BATT  = 2'd2,
        FAST  = 2'd3
    } alert_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PLAY,
        S_ABORT,
        S_GAP
    } sched_state_t;

    // 10 ms qualification and 3 s repeat gap at 50 MHz.
    localparam int QUAL_CYC_50M   = 500_000;
    localparam int REPEAT_CYC_50M = 150_000_000;
    localparam int QUAL_CYC_SIM   = 32;
    localparam int REPEAT_CYC_SIM = 15_000;

    function automatic alert_t pick_alert(input logic q_fast,
                                          input logic q_batt,
                                          input logic q_steer);
        if (q_fast)
            return FAST;
        else if (q_batt)
            return BATT;
        else if (q_steer)
            return STEER;
        else
            return NONE;
    endfunction

endpackage

// File: rtl/alert_qual.sv
// Glitch qualifier for one alert condition.
//   clk, rst_n  clock, asynchronous active-low reset
//   din         raw condition
//   qual        high once din has been high for QUAL_CYC+1 consecutive clocks;
//               drops on the first clock that samples din low
module alert_qual #(
    parameter int QUAL_CYC = 32,
    parameter int QW       = $clog2(QUAL_CYC + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic qual
);

    logic [QW-1:0] cnt;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            qual <= 1'b0;
        end else if (!din) begin
            cnt  <= '0;
            qual <= 1'b0;
        end else begin
            if (cnt != QW'(QUAL_CYC))
                cnt <= cnt + QW'(1);
            // Gating with din makes deassertion take effect on the same edge
            // that clears the counter.
            qual <= (cnt == QW'(QUAL_CYC));
        end
    end

endmodule

// File: rtl/piezo_alert_sched.sv
// Alert scheduler between raw Segway conditions and the piezo tune player.
//   clk, rst_n          clock, asynchronous active-low reset
//   en_steer            rider-present / steering-enabled condition
//   too_fast            over-speed condition
//   batt_low            battery-low condition
//   tone_busy           player is playing a tune (ack of tone_start)
//   tone_start          start request, level, held until tone_busy rises
//   tone_abort          abort request, level, held until tone_busy falls
//   tone_sel[1:0]       tune ID for the player, stable while tone_start or tone_busy
//   alert_act[1:0]      alert currently owned by the scheduler (status LED)
module piezo_alert_sched
    import piezo_pkg::*;
#(
    parameter bit fast_sim   = 1'b1,
    parameter int QUAL_CYC   = fast_sim ? QUAL_CYC_SIM : QUAL_CYC_50M,
    parameter int REPEAT_CYC = fast_sim ? REPEAT_CYC_SIM : REPEAT_CYC_50M,
    parameter int QW         = $clog2(QUAL_CYC + 1),
    parameter int RW         = $clog2(REPEAT_CYC + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_steer,
    input  logic       too_fast,
    input  logic       batt_low,
    input  logic       tone_busy,
    output logic       tone_start,
    output logic       tone_abort,
    output logic [1:0] tone_sel,
    output logic [1:0] alert_act
);

    logic          qual_steer;
    logic          qual_fast;
    logic          qual_batt;
    alert_t        want;
    alert_t        sel_q;
    alert_t        act_q;
    sched_state_t  state;
    logic [RW-1:0] gap_cnt;

    alert_qual #(.QUAL_CYC(QUAL_CYC), .QW(QW)) u_qual_steer (
        .clk (clk),
        .rst_n (rst_n),
        .din (en_steer),
        .qual (qual_steer)
    );

    alert_qual #(.QUAL_CYC(QUAL_CYC), .QW(QW)) u_qual_fast (
        .clk (clk),
        .rst_n (rst_n),
        .din (too_fast),
        .qual (qual_fast)
    );

    alert_qual #(.QUAL_CYC(QUAL_CYC), .QW(QW)) u_qual_batt (
        .clk (clk),
        .rst_n (rst_n),
        .din (batt_low),
        .qual (qual_batt)
    );

    assign want      = pick_alert(qual_fast, qual_batt, qual_steer);
    assign tone_sel  = sel_q;
    assign alert_act = act_q;

    // tone_sel is only ever rewritten in cycles where tone_busy is sampled
    // low, so the player never sees its tune ID change mid-tune.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tone_start <= 1'b0;
            tone_abort <= 1'b0;
            sel_q      <= NONE;
            act_q      <= NONE;
            gap_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (want != NONE) begin
                        sel_q      <= want;
                        act_q      <= want;
                        tone_start <= 1'b1;
                        state      <= S_START;
                    end
                end

                S_START: begin
                    // The ack takes precedence; a higher want seen in the same
                    // cycle is handled as an abort from PLAY.
                    if (tone_busy) begin
                        tone_start <= 1'b0;
                        state      <= S_PLAY;
                    end else if (want == NONE) begin
                        tone_start <= 1'b0;
                        sel_q      <= NONE;
                        act_q      <= NONE;
                        state      <= S_IDLE;
                    end else if (want > sel_q) begin
                        sel_q <= want;
                        act_q <= want;
                    end
                end

                S_PLAY: begin
                    if (!tone_busy) begin
                        // Tune ended: a higher want or a still-present FAST
                        // restarts at once; anything else waits out the gap.
                        if (want > sel_q || (sel_q == FAST && qual_fast)) begin
                            sel_q      <= want;
                            act_q      <= want;
                            tone_start <= 1'b1;
                            state      <= S_START;
                        end else begin
                            sel_q   <= NONE;
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end else if (want > sel_q) begin
                        tone_abort <= 1'b1;
                        state      <= S_ABORT;
                    end
                end

                S_ABORT: begin
                    if (!tone_busy) begin
                        tone_abort <= 1'b0;
                        if (want != NONE) begin
                            sel_q      <= want;
                            act_q      <= want;
                            tone_start <= 1'b1;
                            state      <= S_START;
                        end else begin
                            sel_q <= NONE;
                            act_q <= NONE;
                            state <= S_IDLE;
                        end
                    end
                end

                S_GAP: begin
                    // gap_cnt runs 0..REPEAT_CYC-1, so the gap lasts exactly
                    // REPEAT_CYC cycles before the replay request.
                    if (want == NONE) begin
                        act_q <= NONE;
                        state <= S_IDLE;
                    end else if (want > act_q || gap_cnt == RW'(REPEAT_CYC - 1)) begin
                        sel_q      <= want;
                        act_q      <= want;
                        tone_start <= 1'b1;
                        state      <= S_START;
                    end else begin
                        gap_cnt <= gap_cnt + RW'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
